// File: rtl/fb_pkg.sv
// ----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the framebuffer drawing sequencer:
//   - fb_op_e    : command opcodes carried on the command bus
//   - fb_state_e : sequencer states (the top level maps them to plain
//                  localparam constants for its state register)
//   - FB_RES_X / FB_RES_Y : default framebuffer geometry
//   - FB_BLACK / FB_WHITE : colour helpers in 0b00RRGGBB format
// ----------------------------------------------------------------------------
package fb_pkg;

   localparam int FB_RES_X = 320;
   localparam int FB_RES_Y = 240;

   localparam logic [7:0] FB_BLACK = 8'h00;
   localparam logic [7:0] FB_WHITE = 8'h3F;

   typedef enum logic [1:0] {
      FB_NOP   = 2'd0,
      FB_CLEAR = 2'd1,
      FB_RECT  = 2'd2,
      FB_SWAP  = 2'd3
   } fb_op_e;

   typedef enum logic [2:0] {
      FB_ST_IDLE      = 3'd0,
      FB_ST_FILL      = 3'd1,
      FB_ST_SWAP_REQ  = 3'd2,
      FB_ST_SWAP_WAIT = 3'd3,
      FB_ST_FINISH    = 3'd4
   } fb_state_e;

endpackage

// File: rtl/fb_draw_ctrl_if.sv
// ----------------------------------------------------------------------------
// fb_draw_ctrl_if
// Command bus into the drawing sequencer (valid/ready handshake).
//   cmd_valid  : command present (master -> slave)
//   cmd_ready  : sequencer accepts a command this cycle (slave -> master)
//   cmd_op     : opcode (NOP / CLEAR / RECT / SWAP)
//   cmd_x0/y0  : rectangle top-left corner, inclusive
//   cmd_x1/y1  : rectangle bottom-right corner, inclusive
//   cmd_color  : fill colour for CLEAR and RECT
// Modports: master drives commands, slave is the sequencer.
// ----------------------------------------------------------------------------
interface fb_draw_ctrl_if
   import fb_pkg::*;
#(
   parameter int X_BITS    = 9,
   parameter int Y_BITS    = 8,
   parameter int MEM_WIDTH = 8
);

   logic                 cmd_valid;
   logic                 cmd_ready;
   fb_op_e               cmd_op;
   logic [X_BITS-1:0]    cmd_x0;
   logic [Y_BITS-1:0]    cmd_y0;
   logic [X_BITS-1:0]    cmd_x1;
   logic [Y_BITS-1:0]    cmd_y1;
   logic [MEM_WIDTH-1:0] cmd_color;

   modport master (
      output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
      output cmd_ready
   );

endinterface

// File: rtl/fb_rect_walker.sv
// ----------------------------------------------------------------------------
// fb_rect_walker
// Raster scan counter for a rectangle fill. On start_i it captures the
// (already clipped) corners and points at (x0,y0); on each step_i it moves
// one pixel right, wrapping to x0 of the next row after x1.
//   clk, rst   : clock, synchronous active-high reset
//   start_i    : load a new rectangle
//   step_i     : advance to the next pixel
//   x0_i..y1_i : rectangle corners, inclusive
//   addr_o     : linear framebuffer address of the current pixel
//   last_o     : current pixel is (x1,y1)
// ----------------------------------------------------------------------------
module fb_rect_walker
   import fb_pkg::*;
#(
   parameter int RES_X      = FB_RES_X,
   parameter int X_BITS     = 9,
   parameter int Y_BITS     = 8,
   parameter int ADDR_WIDTH = 17
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  step_i,
   input  logic [X_BITS-1:0]     x0_i,
   input  logic [Y_BITS-1:0]     y0_i,
   input  logic [X_BITS-1:0]     x1_i,
   input  logic [Y_BITS-1:0]     y1_i,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  last_o
);

   localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(RES_X);

   logic [X_BITS-1:0]     x0_q, x1_q, x_q;
   logic [Y_BITS-1:0]     y1_q, y_q;
   logic [ADDR_WIDTH-1:0] rowBase_q;

   // The row base is the only place a multiply appears: it is formed once
   // when a rectangle is loaded, and afterwards advanced by adding one row
   // width each time the scan wraps, so the address path stays an adder.
   always_ff @(posedge clk) begin
      if (rst) begin
         x0_q      <= '0;
         x1_q      <= '0;
         y1_q      <= '0;
         x_q       <= '0;
         y_q       <= '0;
         rowBase_q <= '0;
      end else if (start_i) begin
         x0_q      <= x0_i;
         x1_q      <= x1_i;
         y1_q      <= y1_i;
         x_q       <= x0_i;
         y_q       <= y0_i;
         rowBase_q <= ADDR_WIDTH'(y0_i) * ROW_STEP;
      end else if (step_i) begin
         if (x_q == x1_q) begin
            x_q       <= x0_q;
            y_q       <= y_q + 1'b1;
            rowBase_q <= rowBase_q + ROW_STEP;
         end else begin
            x_q <= x_q + 1'b1;
         end
      end
   end

   assign addr_o = rowBase_q + ADDR_WIDTH'(x_q);
   assign last_o = (x_q == x1_q) && (y_q == y1_q);

endmodule

// File: rtl/fb_draw_ctrl.sv
// ----------------------------------------------------------------------------
// fb_draw_ctrl
// Command-driven drawing sequencer for a double-buffered framebuffer.
// Fills CLEAR/RECT regions of the back buffer one pixel per clock and
// requests buffer swaps synchronised to the frame start.
//   clk, rst  : clock, synchronous active-high reset
//   cmd       : command bus (slave side), see fb_draw_ctrl_if
//   mem_addr  : framebuffer write address
//   din       : framebuffer write data
//   wen       : framebuffer write enable
//   swap_buf  : one-cycle swap request to the framebuffer
//   v_sync    : active-low vsync from the framebuffer
//   busy      : a command is in progress
//   done      : one-cycle pulse when a command completes
// ----------------------------------------------------------------------------
module fb_draw_ctrl
   import fb_pkg::*;
#(
   parameter int RES_X      = FB_RES_X,
   parameter int RES_Y      = FB_RES_Y,
   parameter int MEM_WIDTH  = 8,
   parameter int ADDR_WIDTH = $clog2(RES_X*RES_Y),
   parameter int X_BITS     = $clog2(RES_X),
   parameter int Y_BITS     = $clog2(RES_Y)
)(
   input  logic                  clk,
   input  logic                  rst,
   fb_draw_ctrl_if.slave         cmd,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [MEM_WIDTH-1:0]  din,
   output logic                  wen,
   output logic                  swap_buf,
   input  logic                  v_sync,
   output logic                  busy,
   output logic                  done
);

   localparam logic [2:0] IDLE      = FB_ST_IDLE;
   localparam logic [2:0] FILL      = FB_ST_FILL;
   localparam logic [2:0] SWAP_REQ  = FB_ST_SWAP_REQ;
   localparam logic [2:0] SWAP_WAIT = FB_ST_SWAP_WAIT;
   localparam logic [2:0] FINISH    = FB_ST_FINISH;

   localparam logic [X_BITS-1:0] X_MAX   = X_BITS'(RES_X - 1);
   localparam logic [Y_BITS-1:0] Y_MAX   = Y_BITS'(RES_Y - 1);
   localparam logic [X_BITS:0]   X_LIMIT = (X_BITS+1)'(RES_X);
   localparam logic [Y_BITS:0]   Y_LIMIT = (Y_BITS+1)'(RES_Y);

   logic [2:0]           state_q, state_d;
   logic [MEM_WIDTH-1:0] color_q, color_d;
   logic                 vsync_q;

   logic                 accept;
   logic [X_BITS-1:0]    x1Clip;
   logic [Y_BITS-1:0]    y1Clip;
   logic                 rectEmpty;
   logic                 walkStart;
   logic                 walkLast;
   logic [X_BITS-1:0]    startX0, startX1;
   logic [Y_BITS-1:0]    startY0, startY1;

   // Command decode and next-state logic. Operands are only looked at in
   // IDLE on the accepting cycle; everything needed later is captured into
   // the walker or color_q, so the master may change them afterwards.
   // A rectangle whose origin lies off-screen or whose clipped far corner
   // ends up left of / above the origin produces no writes at all.
   always_comb begin
      accept    = cmd.cmd_valid && (state_q == IDLE);
      x1Clip    = (cmd.cmd_x1 > X_MAX) ? X_MAX : cmd.cmd_x1;
      y1Clip    = (cmd.cmd_y1 > Y_MAX) ? Y_MAX : cmd.cmd_y1;
      rectEmpty = (cmd.cmd_x0 > x1Clip) || (cmd.cmd_y0 > y1Clip) ||
                  ({1'b0, cmd.cmd_x0} >= X_LIMIT) ||
                  ({1'b0, cmd.cmd_y0} >= Y_LIMIT);

      state_d   = state_q;
      color_d   = color_q;
      walkStart = 1'b0;
      startX0   = cmd.cmd_x0;
      startY0   = cmd.cmd_y0;
      startX1   = x1Clip;
      startY1   = y1Clip;

      case (state_q)
         IDLE: begin
            if (accept) begin
               case (cmd.cmd_op)
                  FB_NOP: state_d = FINISH;
                  FB_CLEAR: begin
                     startX0   = '0;
                     startY0   = '0;
                     startX1   = X_MAX;
                     startY1   = Y_MAX;
                     walkStart = 1'b1;
                     color_d   = cmd.cmd_color;
                     state_d   = FILL;
                  end
                  FB_RECT: begin
                     if (rectEmpty) begin
                        state_d = FINISH;
                     end else begin
                        walkStart = 1'b1;
                        color_d   = cmd.cmd_color;
                        state_d   = FILL;
                     end
                  end
                  FB_SWAP: state_d = SWAP_REQ;
                  default: state_d = FINISH;
               endcase
            end
         end
         FILL: begin
            if (walkLast) state_d = FINISH;
         end
         // The request is only issued while vsync is inactive, so it can
         // never coincide with the frame-start window and lose a frame.
         SWAP_REQ: begin
            if (v_sync) state_d = SWAP_WAIT;
         end
         SWAP_WAIT: begin
            if (vsync_q && !v_sync) state_d = FINISH;
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, captured colour and the vsync history used for edge detection.
   // vsync_q resets to the inactive level so a stale low never looks like
   // a falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         color_q <= '0;
         vsync_q <= 1'b1;
      end else begin
         state_q <= state_d;
         color_q <= color_d;
         vsync_q <= v_sync;
      end
   end

   fb_rect_walker #(
      .RES_X      (RES_X),
      .X_BITS     (X_BITS),
      .Y_BITS     (Y_BITS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_walker (
      .clk     (clk),
      .rst     (rst),
      .start_i (walkStart),
      .step_i  (wen),
      .x0_i    (startX0),
      .y0_i    (startY0),
      .x1_i    (startX1),
      .y1_i    (startY1),
      .addr_o  (mem_addr),
      .last_o  (walkLast)
   );

   assign cmd.cmd_ready = (state_q == IDLE);
   assign wen           = (state_q == FILL);
   assign din           = color_q;
   assign swap_buf      = (state_q == SWAP_REQ) && v_sync;
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == FINISH);

endmodule

// File: tb/tb_fb_draw_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fb_draw_ctrl
// Scoreboard bench for fb_draw_ctrl. The stimulus side pushes the expected
// write/swap/done events of each accepted command into a queue, computed
// from the drawing rules with plain loops; a monitor on the falling clock
// edge pops and compares whatever the DUT presents.
// ----------------------------------------------------------------------------
module tb_fb_draw_ctrl;
   import fb_pkg::*;

   localparam int RES_X      = 320;
   localparam int RES_Y      = 240;
   localparam int X_BITS     = 9;
   localparam int Y_BITS     = 8;
   localparam int MEM_WIDTH  = 8;
   localparam int ADDR_WIDTH = 17;

   localparam int EV_WRITE = 0;
   localparam int EV_SWAP  = 1;
   localparam int EV_DONE  = 2;

   typedef struct {
      int kind;
      int addr;
      int data;
      int cyc;
   } ev_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [ADDR_WIDTH-1:0] memAddr;
   logic [MEM_WIDTH-1:0]  din;
   logic                  wen;
   logic                  swapBuf;
   logic                  vSync;
   logic                  busy;
   logic                  done;

   int   checks      = 0;
   int   errors      = 0;
   int   cyc         = 0;
   int   writeCnt    = 0;
   int   swapCnt     = 0;
   int   lastSwapCyc = -1;
   int   lastDoneCyc = -1;
   ev_t  sbq[$];
   ev_t  monEv;

   fb_draw_ctrl_if #(.X_BITS(X_BITS), .Y_BITS(Y_BITS), .MEM_WIDTH(MEM_WIDTH)) cmdIf ();

   fb_draw_ctrl #(
      .RES_X      (RES_X),
      .RES_Y      (RES_Y),
      .MEM_WIDTH  (MEM_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .X_BITS     (X_BITS),
      .Y_BITS     (Y_BITS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd      (cmdIf),
      .mem_addr (memAddr),
      .din      (din),
      .wen      (wen),
      .swap_buf (swapBuf),
      .v_sync   (vSync),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Run-away guard: the whole sequence needs roughly 81k cycles.
   initial begin
      repeat (99000) @(posedge clk);
      $display("[TB] FAIL watchdog expired at cycle %0d, queue depth %0d", cyc, sbq.size());
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   function automatic void pushEv(input int kind, input int addr, input int data, input int c);
      ev_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      e.cyc  = c;
      sbq.push_back(e);
   endfunction

   // Reference behaviour: a command accepted in cycle acc writes its pixels
   // row by row from cycle acc+1 on, then signals done the cycle after the
   // last pixel (or at acc+1 when nothing is drawn). Swaps depend on vsync
   // timing, so their events carry no cycle stamp here.
   function automatic void modelCmd(input int op, input int x0, input int y0,
                                    input int x1, input int y1, input int color,
                                    input int acc);
      int t;
      int ax0;
      int ay0;
      int ax1;
      int ay1;
      t   = acc + 1;
      ax0 = x0;
      ay0 = y0;
      ax1 = -1;
      ay1 = -1;
      if (op == 3) begin
         pushEv(EV_SWAP, 0, 0, -1);
         pushEv(EV_DONE, 0, 0, -1);
         return;
      end
      if (op == 1) begin
         ax0 = 0;
         ay0 = 0;
         ax1 = RES_X - 1;
         ay1 = RES_Y - 1;
      end else if (op == 2) begin
         ax1 = (x1 > RES_X - 1) ? RES_X - 1 : x1;
         ay1 = (y1 > RES_Y - 1) ? RES_Y - 1 : y1;
      end
      if (op != 0 && ax0 <= ax1 && ay0 <= ay1 && ax0 < RES_X && ay0 < RES_Y) begin
         for (int y = ay0; y <= ay1; y++) begin
            for (int x = ax0; x <= ax1; x++) begin
               pushEv(EV_WRITE, y * RES_X + x, color, t);
               t++;
            end
         end
      end
      pushEv(EV_DONE, 0, 0, t);
   endfunction

   // Monitor: every wen/swap_buf/done cycle must match the head of the queue.
   always @(negedge clk) begin
      if (wen === 1'b1) begin
         writeCnt++;
         checks++;
         if (sbq.size() == 0 || sbq[0].kind != EV_WRITE) begin
            errors++;
            $display("[TB] FAIL write_unexpected addr=%0d din=%0h cycle=%0d", memAddr, din, cyc);
         end else begin
            monEv = sbq.pop_front();
            if (int'(memAddr) != monEv.addr || int'(din) != monEv.data || busy !== 1'b1 ||
                (monEv.cyc >= 0 && monEv.cyc != cyc)) begin
               errors++;
               $display("[TB] FAIL write got addr=%0d din=%0h busy=%0b cycle=%0d want addr=%0d din=%0h busy=1 cycle=%0d",
                        memAddr, din, busy, cyc, monEv.addr, monEv.data, monEv.cyc);
            end
         end
      end
      if (swapBuf === 1'b1) begin
         swapCnt++;
         lastSwapCyc = cyc;
         checks++;
         if (sbq.size() == 0 || sbq[0].kind != EV_SWAP) begin
            errors++;
            $display("[TB] FAIL swap_unexpected cycle=%0d", cyc);
         end else begin
            monEv = sbq.pop_front();
         end
      end
      if (done === 1'b1) begin
         lastDoneCyc = cyc;
         checks++;
         if (sbq.size() == 0 || sbq[0].kind != EV_DONE) begin
            errors++;
            $display("[TB] FAIL done_unexpected cycle=%0d pending=%0d", cyc, sbq.size());
         end else begin
            monEv = sbq.pop_front();
            if (monEv.cyc >= 0 && monEv.cyc != cyc) begin
               errors++;
               $display("[TB] FAIL done_timing got cycle=%0d want cycle=%0d", cyc, monEv.cyc);
            end
         end
      end
   end

   // Called just after a rising edge. Holds the command until accepted,
   // records the expectation, then scrambles the operands.
   task automatic applyStimulus(input int op, input int x0, input int y0,
                                input int x1, input int y1, input int color);
      int guard;
      guard = 0;
      cmdIf.cmd_valid = 1'b1;
      cmdIf.cmd_op    = fb_op_e'(2'(op));
      cmdIf.cmd_x0    = X_BITS'(x0);
      cmdIf.cmd_y0    = Y_BITS'(y0);
      cmdIf.cmd_x1    = X_BITS'(x1);
      cmdIf.cmd_y1    = Y_BITS'(y1);
      cmdIf.cmd_color = MEM_WIDTH'(color);
      while (cmdIf.cmd_ready !== 1'b1 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (cmdIf.cmd_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout ready=%b wanted 1", cmdIf.cmd_ready);
         cmdIf.cmd_valid = 1'b0;
         return;
      end
      modelCmd(op, x0, y0, x1, y1, color, cyc);
      @(posedge clk); #1;
      cmdIf.cmd_valid = 1'b0;
      cmdIf.cmd_x0    = X_BITS'($urandom);
      cmdIf.cmd_y0    = Y_BITS'($urandom);
      cmdIf.cmd_x1    = X_BITS'($urandom);
      cmdIf.cmd_y1    = Y_BITS'($urandom);
      cmdIf.cmd_color = MEM_WIDTH'($urandom);
   endtask

   task automatic waitDone(input string name, input int limit);
      int guard;
      int readyHigh;
      guard     = 0;
      readyHigh = 0;
      while (sbq.size() != 0 && guard < limit) begin
         if (cmdIf.cmd_ready !== 1'b0) readyHigh = 1;
         @(posedge clk); #1;
         guard++;
      end
      checkOutput({name, "_pending"}, sbq.size(), 0);
      checkOutput({name, "_ready_high"}, readyHigh, 0);
      sbq.delete();
   endtask

   initial begin
      int w0;
      int s0;
      int riseCyc;
      int fallCyc;
      int bad;
      int guard;
      int op;
      int x0;
      int y0;
      int x1;
      int y1;

      rst             = 1'b1;
      vSync           = 1'b1;
      cmdIf.cmd_valid = 1'b0;
      cmdIf.cmd_op    = FB_NOP;
      cmdIf.cmd_x0    = '0;
      cmdIf.cmd_y0    = '0;
      cmdIf.cmd_x1    = '0;
      cmdIf.cmd_y1    = '0;
      cmdIf.cmd_color = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      checkOutput("rst_ready",    int'(cmdIf.cmd_ready), 1);
      checkOutput("rst_wen",      int'(wen), 0);
      checkOutput("rst_swap",     int'(swapBuf), 0);
      checkOutput("rst_busy",     int'(busy), 0);
      checkOutput("rst_done",     int'(done), 0);
      checkOutput("rst_mem_addr", int'(memAddr), 0);
      checkOutput("rst_din",      int'(din), 0);

      // Small rectangle: addresses 322..324, 642..644.
      w0 = writeCnt;
      applyStimulus(FB_RECT, 2, 1, 4, 2, 'h30);
      waitDone("rect_small", 50);
      checkOutput("rect_small_writes", writeCnt - w0, 6);

      w0 = writeCnt;
      applyStimulus(FB_NOP, 0, 0, 0, 0, 0);
      waitDone("nop", 10);

      applyStimulus(FB_RECT, 5, 5, 3, 9, 'h11);
      waitDone("rect_inverted", 10);
      applyStimulus(FB_RECT, 330, 4, 335, 6, 'h22);
      waitDone("rect_offscreen", 10);
      checkOutput("empty_writes", writeCnt - w0, 0);

      w0 = writeCnt;
      applyStimulus(FB_RECT, 318, 238, 400, 255, FB_WHITE);
      waitDone("rect_clip", 20);
      checkOutput("rect_clip_writes", writeCnt - w0, 4);

      w0 = writeCnt;
      applyStimulus(FB_CLEAR, 0, 0, 0, 0, FB_BLACK);
      waitDone("clear", 77000);
      checkOutput("clear_writes", writeCnt - w0, RES_X * RES_Y);

      // Swap: held off while vsync is low, pulses on the rise, completes on
      // the next falling edge.
      vSync = 1'b0;
      @(posedge clk); #1;
      s0 = swapCnt;
      applyStimulus(FB_SWAP, 0, 0, 0, 0, 0);
      bad = 0;
      repeat (6) begin
         if (swapBuf !== 1'b0 || cmdIf.cmd_ready !== 1'b0) bad = 1;
         @(posedge clk); #1;
      end
      checkOutput("swap_held_off", bad, 0);
      riseCyc = cyc;
      vSync   = 1'b1;
      repeat (4) begin
         if (cmdIf.cmd_ready !== 1'b0) bad = 1;
         @(posedge clk); #1;
      end
      checkOutput("swap_wait_ready", bad, 0);
      fallCyc = cyc;
      vSync   = 1'b0;
      waitDone("swap", 20);
      checkOutput("swap_pulses", swapCnt - s0, 1);
      checkOutput("swap_pulse_cycle", lastSwapCyc, riseCyc);
      checkOutput("swap_done_cycle", lastDoneCyc, fallCyc + 1);
      vSync = 1'b1;
      @(posedge clk); #1;

      // Reset after ten writes of a CLEAR.
      w0 = writeCnt;
      applyStimulus(FB_CLEAR, 0, 0, 0, 0, 'h15);
      guard = 0;
      while (writeCnt - w0 < 10 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      sbq.delete();
      checkOutput("midrst_wen",   int'(wen), 0);
      checkOutput("midrst_ready", int'(cmdIf.cmd_ready), 1);
      checkOutput("midrst_busy",  int'(busy), 0);
      checkOutput("midrst_count", writeCnt - w0, 11);
      rst = 1'b0;
      w0 = writeCnt;
      applyStimulus(FB_RECT, 10, 20, 12, 21, FB_WHITE);
      waitDone("post_rst_rect", 30);
      checkOutput("post_rst_writes", writeCnt - w0, 6);

      // Random NOP/RECT traffic, including clipped, inverted and off-screen
      // rectangles.
      for (int i = 0; i < 40; i++) begin
         op = ($urandom_range(0, 4) == 0) ? 0 : 2;
         x0 = $urandom_range(0, 335);
         y0 = $urandom_range(0, 245);
         x1 = x0 + $urandom_range(1, 10) - 1;
         y1 = y0 + $urandom_range(1, 6) - 1;
         if ($urandom_range(0, 9) == 0 && x0 > 0) x1 = x0 - 1;
         if ($urandom_range(0, 9) == 0 && y0 > 0) y1 = y0 - 1;
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         applyStimulus(op, x0, y0, x1, y1, $urandom_range(0, 63));
         waitDone("random", 200);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
